// File: rtl/pkt_relay_pkg.sv
// Shared types and default parameter values for the pkt_relay frame relay.
package pkt_relay_pkg;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_DELAY   = 1;
   localparam int DEF_CNT_W   = 16;
   localparam int DEF_MIN_IFG = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FRAME = 2'd1,
      ST_GAP   = 2'd2
   } relay_state_e;

endpackage

// File: rtl/pkt_delay_line.sv
// Fixed-latency register pipeline, DEPTH stages of W bits, cleared by async reset.
module pkt_delay_line #(
   parameter int W     = 9,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pkt_relay.sv
// Frame relay: forwards or drops whole rx_dv frames through a DELAY-cycle pipeline.
// Frame statistics and gap checking are built only when PKT_RELAY_STATS_EN is defined.
import pkt_relay_pkg::*;

module pkt_relay #(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DELAY   = DEF_DELAY,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int MIN_IFG = DEF_MIN_IFG
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] rxd,
   input  logic              rx_dv,
   input  logic              enable,
   output logic [DATA_W-1:0] txd,
   output logic              tx_en,
   output logic              busy,
   output logic              ifg_err,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic [CNT_W-1:0]  last_len
);

   relay_state_e      state_q;
   logic              fwd_q;
   logic              busy_q;
   logic              frame_start;
   logic              fwd_now;
   logic [DATA_W:0]   dl_in;
   logic [DATA_W:0]   dl_out;

   // enable is only looked at on the frame's first cycle; fwd_q holds the decision after that.
   always_comb begin
      frame_start = rx_dv && (state_q != ST_FRAME);
      fwd_now     = frame_start ? enable : fwd_q;
      dl_in       = (rx_dv && fwd_now) ? {1'b1, rxd} : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         fwd_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_GAP: begin
               if (rx_dv) begin
                  state_q <= ST_FRAME;
                  fwd_q   <= enable;
                  busy_q  <= 1'b1;
               end
            end
            ST_FRAME: begin
               if (!rx_dv) begin
                  state_q <= ST_GAP;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;

   pkt_delay_line #(
      .W     (DATA_W + 1),
      .DEPTH (DELAY)
   ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (dl_in),
      .q_o   (dl_out)
   );

   assign txd   = dl_out[DATA_W-1:0];
   assign tx_en = dl_out[DATA_W];

`ifdef PKT_RELAY_STATS_EN
   localparam int GAP_W = (MIN_IFG < 1) ? 1 : $clog2(MIN_IFG + 1);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_IFG);

   logic [GAP_W-1:0] gap_q,   gap_d;
   logic [CNT_W-1:0] len_q,   len_d;
   logic [CNT_W-1:0] frame_q, frame_d;
   logic [CNT_W-1:0] drop_q,  drop_d;
   logic [CNT_W-1:0] last_q,  last_d;
   logic             ifg_q,   ifg_d;
   logic             frame_end;

   // The gap counter restarts at each frame start, so the first idle cycle after a frame counts as 1.
   always_comb begin
      frame_end = !rx_dv && (state_q == ST_FRAME);
      gap_d     = gap_q;
      len_d     = len_q;
      frame_d   = frame_q;
      drop_d    = drop_q;
      last_d    = last_q;
      ifg_d     = 1'b0;
      if (frame_start) begin
         len_d = CNT_W'(1);
         gap_d = '0;
         ifg_d = (state_q == ST_GAP) && (gap_q < GAP_MAX);
      end else if (rx_dv) begin
         if (len_q != '1) len_d = len_q + CNT_W'(1);
      end
      if (!rx_dv && (gap_q != GAP_MAX)) gap_d = gap_q + GAP_W'(1);
      if (frame_end) begin
         if (fwd_q) begin
            last_d = len_q;
            if (frame_q != '1) frame_d = frame_q + CNT_W'(1);
         end else if (drop_q != '1) begin
            drop_d = drop_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_q   <= '0;
         len_q   <= '0;
         frame_q <= '0;
         drop_q  <= '0;
         last_q  <= '0;
         ifg_q   <= 1'b0;
      end else begin
         gap_q   <= gap_d;
         len_q   <= len_d;
         frame_q <= frame_d;
         drop_q  <= drop_d;
         last_q  <= last_d;
         ifg_q   <= ifg_d;
      end
   end

   assign ifg_err   = ifg_q;
   assign frame_cnt = frame_q;
   assign drop_cnt  = drop_q;
   assign last_len  = last_q;
`else
   localparam int unused_min_ifg = MIN_IFG;

   assign ifg_err   = 1'b0;
   assign frame_cnt = '0;
   assign drop_cnt  = '0;
   assign last_len  = '0;
`endif

endmodule

// File: tb/tb_pkt_relay.sv
// Directed bench for pkt_relay: a DELAY=3 instance and a DELAY=1/CNT_W=4 instance share stimulus.
module tb_pkt_relay;

`ifdef PKT_RELAY_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rxd = '0;
   logic        rx_dv = 1'b0;
   logic        enable = 1'b0;

   logic [7:0]  a_txd, b_txd;
   logic        a_tx_en, b_tx_en, a_busy, b_busy, a_ifg, b_ifg;
   logic [15:0] a_fcnt, a_dcnt, a_llen;
   logic [3:0]  b_fcnt, b_dcnt, b_llen;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pkt_relay #(.DATA_W(8), .DELAY(3), .CNT_W(16), .MIN_IFG(12)) dut_a (
      .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_dv(rx_dv), .enable(enable),
      .txd(a_txd), .tx_en(a_tx_en), .busy(a_busy), .ifg_err(a_ifg),
      .frame_cnt(a_fcnt), .drop_cnt(a_dcnt), .last_len(a_llen)
   );

   pkt_relay #(.DATA_W(8), .DELAY(1), .CNT_W(4), .MIN_IFG(12)) dut_b (
      .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_dv(rx_dv), .enable(enable),
      .txd(b_txd), .tx_en(b_tx_en), .busy(b_busy), .ifg_err(b_ifg),
      .frame_cnt(b_fcnt), .drop_cnt(b_dcnt), .last_len(b_llen)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      rx_dv  = 1'b0;
      rxd    = '0;
      enable = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      step();
      checks++;
      if ({a_txd, a_tx_en, a_busy, a_ifg, a_fcnt, a_dcnt, a_llen} !== '0) begin
         errors++;
         $display("FAIL reset_a got txd=%h en=%b busy=%b ifg=%b f=%0d d=%0d l=%0d want all 0",
                  a_txd, a_tx_en, a_busy, a_ifg, a_fcnt, a_dcnt, a_llen);
      end
      checks++;
      if ({b_txd, b_tx_en, b_busy, b_ifg, b_fcnt, b_dcnt, b_llen} !== '0) begin
         errors++;
         $display("FAIL reset_b got txd=%h en=%b busy=%b ifg=%b f=%0d d=%0d l=%0d want all 0",
                  b_txd, b_tx_en, b_busy, b_ifg, b_fcnt, b_dcnt, b_llen);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_forward();
      logic [7:0] d [9];
      logic       dv [9];
      logic [7:0] exp_a;
      d  = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h00, 8'h00, 8'h00, 8'h00};
      dv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         rxd    = d[i];
         rx_dv  = dv[i];
         enable = (i < 2);
         step();
         exp_a = (i >= 2) ? d[i-2] : 8'h00;
         checks++;
         if ({a_tx_en, a_txd} !== {(i >= 2) ? dv[i-2] : 1'b0, exp_a}) begin
            errors++;
            $display("FAIL fwd_a cycle %0d got en=%b txd=%h want en=%b txd=%h",
                     i, a_tx_en, a_txd, (i >= 2) ? dv[i-2] : 1'b0, exp_a);
         end
         checks++;
         if ({b_tx_en, b_txd, b_busy} !== {dv[i], d[i], dv[i]}) begin
            errors++;
            $display("FAIL fwd_b cycle %0d got en=%b txd=%h busy=%b want en=%b txd=%h busy=%b",
                     i, b_tx_en, b_txd, b_busy, dv[i], d[i], dv[i]);
         end
      end
      checks++;
      if ({a_fcnt, a_dcnt, a_llen} !== {STATS ? 16'd1 : 16'd0, 16'd0, STATS ? 16'd5 : 16'd0}) begin
         errors++;
         $display("FAIL fwd_stats got f=%0d d=%0d l=%0d want f=%0d d=0 l=%0d",
                  a_fcnt, a_dcnt, a_llen, STATS ? 1 : 0, STATS ? 5 : 0);
      end
   endtask

   task automatic test_drop();
      bit seen_a;
      bit seen_b;
      seen_a = 1'b0;
      seen_b = 1'b0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         rx_dv  = (i < 4);
         rxd    = (i < 4) ? 8'(8'h21 + i) : 8'h00;
         enable = (i >= 1);
         step();
         if (a_tx_en || a_txd != 8'h00) seen_a = 1'b1;
         if (b_tx_en || b_txd != 8'h00) seen_b = 1'b1;
      end
      checks++;
      if ({seen_a, seen_b} !== 2'b00) begin
         errors++;
         $display("FAIL drop_tx got a_active=%b b_active=%b want 0 0", seen_a, seen_b);
      end
      checks++;
      if ({a_fcnt, a_dcnt, b_dcnt} !== {16'd0, STATS ? 16'd1 : 16'd0, STATS ? 4'd1 : 4'd0}) begin
         errors++;
         $display("FAIL drop_stats got a_f=%0d a_d=%0d b_d=%0d want 0 %0d %0d",
                  a_fcnt, a_dcnt, b_dcnt, STATS ? 1 : 0, STATS ? 1 : 0);
      end
   endtask

   task automatic test_ifg(input int gap);
      int  n;
      bit  dv;
      bit  exp_err;
      n = 9 + gap;
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < n; i++) begin
         dv      = (i < 3) || (i >= 3 + gap && i < 6 + gap);
         rx_dv   = dv;
         rxd     = dv ? 8'(i + 1) : 8'h00;
         step();
         exp_err = STATS && (gap < 12) && (i == 3 + gap);
         checks++;
         if ({a_ifg, b_ifg} !== {exp_err, exp_err}) begin
            errors++;
            $display("FAIL ifg_gap%0d cycle %0d got a=%b b=%b want %b", gap, i, a_ifg, b_ifg, exp_err);
         end
         checks++;
         if ({b_tx_en, b_txd} !== {dv, dv ? 8'(i + 1) : 8'h00}) begin
            errors++;
            $display("FAIL ifg_tx_gap%0d cycle %0d got en=%b txd=%h want en=%b", gap, i, b_tx_en, b_txd, dv);
         end
      end
      checks++;
      if (a_fcnt !== (STATS ? 16'd2 : 16'd0)) begin
         errors++;
         $display("FAIL ifg_fcnt_gap%0d got %0d want %0d", gap, a_fcnt, STATS ? 2 : 0);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rx_dv = 1'b1;
         rxd   = 8'(8'h30 + i);
         step();
      end
      rxd = 8'h32;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({b_txd, b_tx_en, a_busy, b_busy, a_fcnt, a_llen, b_fcnt} !== '0) begin
         errors++;
         $display("FAIL rstmid_clear got b_txd=%h b_en=%b a_busy=%b b_busy=%b a_f=%0d a_l=%0d b_f=%0d want all 0",
                  b_txd, b_tx_en, a_busy, b_busy, a_fcnt, a_llen, b_fcnt);
      end
      step();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rxd = 8'(8'h40 + k);
         step();
         checks++;
         if ({b_tx_en, b_txd, b_ifg, a_ifg} !== {1'b1, 8'(8'h40 + k), 2'b00}) begin
            errors++;
            $display("FAIL rstmid_new step %0d got en=%b txd=%h ifg=%b%b want en=1 txd=%h ifg=00",
                     k, b_tx_en, b_txd, b_ifg, a_ifg, 8'(8'h40 + k));
         end
         if (k == 0) begin
            checks++;
            if ({a_tx_en, a_txd} !== 9'h000) begin
               errors++;
               $display("FAIL rstmid_pipe got en=%b txd=%h want en=0 txd=00", a_tx_en, a_txd);
            end
         end
      end
      checks++;
      if ({a_tx_en, a_txd} !== {1'b1, 8'h40}) begin
         errors++;
         $display("FAIL rstmid_a_lat got en=%b txd=%h want en=1 txd=40", a_tx_en, a_txd);
      end
      rx_dv = 1'b0;
      rxd   = 8'h00;
      step();
      checks++;
      if ({a_fcnt, a_llen, a_ifg} !== {STATS ? 16'd1 : 16'd0, STATS ? 16'd3 : 16'd0, 1'b0}) begin
         errors++;
         $display("FAIL rstmid_stats got f=%0d l=%0d ifg=%b want f=%0d l=%0d ifg=0",
                  a_fcnt, a_llen, a_ifg, STATS ? 1 : 0, STATS ? 3 : 0);
      end
   endtask

   task automatic test_saturate();
      bit ifg_seen;
      ifg_seen = 1'b0;
      do_reset();
      enable = 1'b1;
      for (int f = 0; f < 20; f++) begin
         rx_dv = 1'b1;
         rxd   = 8'(f);
         step();
         if (a_ifg || b_ifg) ifg_seen = 1'b1;
         if (f == 0) begin
            checks++;
            if ({b_tx_en, b_txd} !== {1'b1, 8'h00}) begin
               errors++;
               $display("FAIL sat_single got en=%b txd=%h want en=1 txd=00", b_tx_en, b_txd);
            end
         end
         rx_dv = 1'b0;
         rxd   = 8'h00;
         for (int g = 0; g < 12; g++) begin
            step();
            if (a_ifg || b_ifg) ifg_seen = 1'b1;
         end
      end
      checks++;
      if (ifg_seen !== 1'b0) begin
         errors++;
         $display("FAIL sat_ifg got ifg pulse=%b want 0", ifg_seen);
      end
      checks++;
      if ({b_fcnt, b_llen} !== {STATS ? 4'd15 : 4'd0, STATS ? 4'd1 : 4'd0}) begin
         errors++;
         $display("FAIL sat_b got f=%0d l=%0d want f=%0d l=%0d", b_fcnt, b_llen, STATS ? 15 : 0, STATS ? 1 : 0);
      end
      checks++;
      if ({a_fcnt, a_llen} !== {STATS ? 16'd20 : 16'd0, STATS ? 16'd1 : 16'd0}) begin
         errors++;
         $display("FAIL sat_a got f=%0d l=%0d want f=%0d l=%0d", a_fcnt, a_llen, STATS ? 20 : 0, STATS ? 1 : 0);
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_drop();
      test_ifg(5);
      test_ifg(11);
      test_ifg(12);
      test_reset_mid();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pkt_relay.md
PKT_RELAY -- requirements
Module: pkt_relay

Interface
REQ-001 Parameter DATA_W, default 8, data bus width in bits (range 1..64).
REQ-002 Parameter DELAY, default 1, pipeline latency in clk cycles (range 1..16).
REQ-003 Parameter CNT_W, default 16, width of statistics counters.
REQ-004 Parameter MIN_IFG, default 12, minimum legal idle cycles between frames.
REQ-005 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 rxd  input  DATA_W  receive data, valid when rx_dv=1.
REQ-008 rx_dv  input  1  receive data valid; one contiguous high run is one frame.
REQ-009 enable  input  1  forward enable, sampled only at frame start.
REQ-010 txd  output  DATA_W  transmit data, registered.
REQ-011 tx_en  output  1  transmit enable, registered.
REQ-012 busy  output  1  high while FSM is in FRAME.
REQ-013 ifg_err  output  1  one-cycle pulse on inter-frame-gap violation.
REQ-014 frame_cnt  output  CNT_W  forwarded-frame count.
REQ-015 drop_cnt  output  CNT_W  dropped-frame count.
REQ-016 last_len  output  CNT_W  length in cycles of most recent forwarded frame.

Function
REQ-017 FSM states IDLE (post-reset, no gap history), FRAME, GAP; transitions: IDLE/GAP->FRAME on rx_dv=1; FRAME->GAP on rx_dv=0; no other transitions.
REQ-018 Frame start = cycle rx_dv=1 while FSM in IDLE or GAP; enable sampled that cycle fixes forward/drop for the whole frame.
REQ-019 Forwarded frame: rxd/rx_dv of cycle N SHALL appear on txd/tx_en after exactly DELAY clk edges; DELAY=1 gives a plain one-register relay.
REQ-020 Dropped frame: its cycles SHALL enter the delay line as rx_dv=0, rxd=0; tx_en stays 0 and txd stays 0 for them.
REQ-021 Non-frame cycles (rx_dv=0) SHALL enter the delay line as rxd=0, rx_dv=0.
REQ-022 enable changes mid-frame SHALL have no effect until the next frame start.
REQ-023 GAP idle counter counts rx_dv=0 cycles, saturating at MIN_IFG; frame start from GAP with count < MIN_IFG SHALL pulse ifg_err the following cycle; frame is still forwarded/dropped per enable.
REQ-024 Frame start from IDLE SHALL never raise ifg_err.
REQ-025 Length counter counts rx_dv=1 cycles of current frame, saturating at all-ones; on forwarded frame end last_len SHALL update the cycle after rx_dv falls.
REQ-026 frame_cnt (forwarded) or drop_cnt (dropped) SHALL increment by 1 the cycle after rx_dv falls; all counters saturate at all-ones, no wrap.
REQ-027 Single-cycle frame is legal: last_len=1.

Reset
REQ-028 rst_n=0 SHALL immediately clear all delay stages, txd=0, tx_en=0, busy=0, ifg_err=0, all counters 0, FSM=IDLE.
REQ-029 Reset mid-frame SHALL abort the frame with no counter update; after release, a still-high rx_dv SHALL be treated as a new frame start from IDLE.

Configuration
REQ-030 Macro PKT_RELAY_STATS_EN defined: ifg_err, frame_cnt, drop_cnt, last_len behave per REQ-023..027.
REQ-031 Macro PKT_RELAY_STATS_EN undefined: those ports SHALL remain present and tied to 0, the counter logic omitted; forwarding, drop and FSM behaviour unchanged.

Structure
REQ-032 Package pkt_relay_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-033 Sub-module pkt_delay_line (parametrised DATA_W+1 bits by DELAY stages, async reset) SHALL implement the latency pipeline.

Verification
REQ-034 DELAY=3, enable=1, 5-cycle frame 0x11..0x15 -> same bytes on txd with tx_en=1 starting 3 edges later, frame_cnt=1, last_len=5.
REQ-035 enable=0 at frame start, raised mid-frame, 4-cycle frame -> tx_en never 1, drop_cnt=1, frame_cnt=0.
REQ-036 MIN_IFG=12, two frames separated by 5 idle cycles -> one ifg_err pulse, both frames forwarded, frame_cnt=2.
REQ-037 rst_n pulled low in cycle 3 of 8-cycle frame -> txd=0, tx_en=0 at once, counters 0; rx_dv still high at release counts as new frame, no ifg_err.
REQ-038 CNT_W=4, 20 single-cycle frames with 12-cycle gaps -> frame_cnt saturates at 15, last_len=1.
REQ-039 Build without PKT_RELAY_STATS_EN, rerun REQ-034 -> identical txd/tx_en, stats ports constant 0.
